// File: rtl/bt_cmd_pkg.sv
// Shared constants and FSM state type for the Bluetooth remote-command decoder.
package bt_cmd_pkg;

  localparam logic [7:0] CMD_KEEPALIVE = 8'h00;
  localparam logic [7:0] CMD_PREV      = 8'h01;
  localparam logic [7:0] CMD_NEXT      = 8'h02;
  localparam logic [7:0] CMD_VOL_UP    = 8'h03;
  localparam logic [7:0] CMD_VOL_DOWN  = 8'h04;
  localparam logic [7:0] CMD_JUMP_BASE = 8'h05;

  localparam logic [7:0] ACK_FLAG = 8'h80;
  localparam logic [7:0] ACK_ERR  = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_ACK
  } state_t;

endpackage

// File: rtl/bt_track_dist.sv
// Combinational track-jump distance: target/current index -> backward/forward step count,
// either linear or shortest circular path (ties step forward).
module bt_track_dist #(
  parameter int TRACK_NUM = 7,
  parameter int WRAP      = 0,
  parameter int TRK_W     = 3
) (
  input  logic [TRK_W-1:0] target,
  input  logic [TRK_W-1:0] cur,
  output logic [TRK_W-1:0] prev,
  output logic [TRK_W-1:0] next
);

  if (WRAP != 0) begin : g_wrap
    localparam logic [TRK_W:0] NUM = (TRK_W+1)'(TRACK_NUM);
    logic [TRK_W:0] fwd;
    logic [TRK_W:0] bwd;

    always_comb begin
      prev = '0;
      next = '0;
      fwd  = (target >= cur) ? ({1'b0, target} - {1'b0, cur})
                             : ({1'b0, target} + NUM - {1'b0, cur});
      bwd  = (fwd == '0) ? '0 : (NUM - fwd);
      if (bwd < fwd) prev = bwd[TRK_W-1:0];
      else           next = fwd[TRK_W-1:0];
    end
  end else begin : g_linear
    always_comb begin
      prev = '0;
      next = '0;
      if (target < cur) prev = cur - target;
      else              next = target - cur;
    end
  end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Bluetooth remote-command decoder: RX byte -> PREV/NEXT/UP/DOWN command handshake,
// one-entry pending buffer with drop counter. Acknowledge path enabled by BT_CMD_ACK_EN.
module bt_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int TRACK_NUM = 7,
  parameter int WRAP      = 0,
  parameter int TRK_W     = ($clog2(TRACK_NUM) > 1) ? $clog2(TRACK_NUM) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_VALID,
  input  logic [7:0]       RX_DATA,
  input  logic [TRK_W-1:0] CUR_TRACK,
  output logic             CMD_VALID,
  input  logic             CMD_READY,
  output logic [TRK_W-1:0] PREV,
  output logic [TRK_W-1:0] NEXT,
  output logic             UP,
  output logic             DOWN,
  output logic             TX_VALID,
  output logic [7:0]       TX_DATA,
  input  logic             TX_READY,
  output logic             ERR,
  output logic [7:0]       DROP_CNT
);

  localparam logic [TRK_W-1:0] LAST_TRACK = TRK_W'(TRACK_NUM - 1);
  localparam logic [8:0]       JUMP_END   = 9'(CMD_JUMP_BASE) + 9'(TRACK_NUM);

  state_t           state;
  logic [7:0]       cmd_byte;
  logic [7:0]       pend_byte;
  logic             pend_full;
  logic [TRK_W-1:0] cur_clamp;
  logic [TRK_W-1:0] target;
  logic [TRK_W-1:0] dist_prev;
  logic [TRK_W-1:0] dist_next;
  logic [TRK_W-1:0] dec_prev;
  logic [TRK_W-1:0] dec_next;
  logic             dec_up;
  logic             dec_down;
  logic             dec_err;
  logic             dec_cmd;
  logic             is_jump;
  logic             rx_hit;
  logic             fin;

  bt_track_dist #(
    .TRACK_NUM (TRACK_NUM),
    .WRAP      (WRAP),
    .TRK_W     (TRK_W)
  ) u_dist (
    .target (target),
    .cur    (cur_clamp),
    .prev   (dist_prev),
    .next   (dist_next)
  );

  always_comb begin
    rx_hit    = RX_VALID && (RX_DATA != CMD_KEEPALIVE);
    cur_clamp = (int'(CUR_TRACK) >= TRACK_NUM) ? LAST_TRACK : CUR_TRACK;
    is_jump   = (cmd_byte >= CMD_JUMP_BASE) && ({1'b0, cmd_byte} < JUMP_END);
    target    = TRK_W'(cmd_byte - CMD_JUMP_BASE);

    dec_prev = '0;
    dec_next = '0;
    dec_up   = 1'b0;
    dec_down = 1'b0;
    dec_err  = 1'b0;
    case (cmd_byte)
      CMD_PREV:     dec_prev = TRK_W'(1);
      CMD_NEXT:     dec_next = TRK_W'(1);
      CMD_VOL_UP:   dec_up   = 1'b1;
      CMD_VOL_DOWN: dec_down = 1'b1;
      default: begin
        if (is_jump) begin
          dec_prev = dist_prev;
          dec_next = dist_next;
        end else begin
          dec_err = 1'b1;
        end
      end
    endcase
    dec_cmd = dec_up | dec_down | (dec_prev != '0) | (dec_next != '0);

    // fin marks the last cycle of a command; the next byte is taken from here
`ifdef BT_CMD_ACK_EN
    fin = (state == ST_ACK) && TX_READY;
`else
    fin = ((state == ST_ISSUE) && CMD_READY) || ((state == ST_DECODE) && !dec_cmd);
`endif
  end

`ifndef BT_CMD_ACK_EN
  logic unused_tx_ready;
  assign unused_tx_ready = TX_READY;
  assign TX_VALID = 1'b0;
  assign TX_DATA  = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cmd_byte  <= '0;
      pend_byte <= '0;
      pend_full <= 1'b0;
      CMD_VALID <= 1'b0;
      PREV      <= '0;
      NEXT      <= '0;
      UP        <= 1'b0;
      DOWN      <= 1'b0;
      ERR       <= 1'b0;
      DROP_CNT  <= '0;
`ifdef BT_CMD_ACK_EN
      TX_VALID  <= 1'b0;
      TX_DATA   <= '0;
`endif
    end else begin
      ERR <= 1'b0;

      // A byte arriving as the current command finishes is never dropped: it either
      // refills the pending slot being consumed or is decoded directly.
      if ((state != ST_IDLE) && rx_hit) begin
        if (fin) begin
          if (pend_full) pend_byte <= RX_DATA;
        end else if (!pend_full) begin
          pend_full <= 1'b1;
          pend_byte <= RX_DATA;
        end else if (DROP_CNT != 8'hFF) begin
          DROP_CNT <= DROP_CNT + 8'd1;
        end
      end else if (fin) begin
        pend_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rx_hit) begin
            cmd_byte <= RX_DATA;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          CMD_VALID <= dec_cmd;
          PREV      <= dec_prev;
          NEXT      <= dec_next;
          UP        <= dec_up;
          DOWN      <= dec_down;
          ERR       <= dec_err;
          if (dec_cmd) state <= ST_ISSUE;
`ifdef BT_CMD_ACK_EN
          else begin
            TX_VALID <= 1'b1;
            TX_DATA  <= dec_err ? ACK_ERR : (ACK_FLAG | cmd_byte);
            state    <= ST_ACK;
          end
`endif
        end
        ST_ISSUE: begin
          if (CMD_READY) begin
            CMD_VALID <= 1'b0;
            PREV      <= '0;
            NEXT      <= '0;
            UP        <= 1'b0;
            DOWN      <= 1'b0;
`ifdef BT_CMD_ACK_EN
            TX_VALID  <= 1'b1;
            TX_DATA   <= ACK_FLAG | cmd_byte;
            state     <= ST_ACK;
`endif
          end
        end
`ifdef BT_CMD_ACK_EN
        ST_ACK: begin
          if (TX_READY) begin
            TX_VALID <= 1'b0;
            TX_DATA  <= '0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase

      // Overrides the per-state next state when a command completes
      if (fin) begin
        if (pend_full) begin
          cmd_byte <= pend_byte;
          state    <= ST_DECODE;
        end else if (rx_hit) begin
          cmd_byte <= RX_DATA;
          state    <= ST_DECODE;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule
